gray_ptr_ctrl: RTL and testbench

- Parametrised single-side pointer controller for the async FIFO; one instance is the write side, another the read side.
- Holds the local binary and Gray pointer and synchronises the remote Gray pointer into this clock domain.
- Converts the synchronised remote pointer Gray→binary and produces registered full/empty, almost and level outputs.
- Generalises the stand-alone Norm2Gray/Gray2Norm conversion into a clocked, depth-parametrised pointer unit with a selectable side mode.

---
 rtl/gray_ptr_ctrl.sv | 138 +++++++++++++
 tb/tb_gray_ptr_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_ptr_ctrl.sv
// Purpose : one side of an async FIFO: local binary/Gray pointer, remote Gray sync, full|empty/almost/level.
// Latency : local Inc -> Flag/Almost/Level after 1 edge; remote pointer change -> SYNC_STAGES+1 edges.
// Backpr. : Ack = Inc & ~Flag; an Inc while Flag is set is dropped and sets the sticky Err.
//
// Ports:
//   Clk, Rst_n     clock, synchronous active-low reset
//   Clr            local clear of pointer, flags and error (sync chain keeps running)
//   Inc / Ack      advance request / accepted this cycle (combinational)
//   Addr           RAM address (low bits of the binary pointer)
//   Ptr_gray       registered local Gray pointer, sent to the other domain
//   Rmt_gray       remote Gray pointer from the other clock domain
//   Flag, Almost   full/almost-full (WR_SIDE=1) or empty/almost-empty (WR_SIDE=0)
//   Level          occupancy 0..depth
//   Err            sticky overflow/underflow attempt
module gray_ptr_ctrl #(
   parameter int ADDR_WIDTH  = 4,
   parameter int SYNC_STAGES = 2,
   parameter bit WR_SIDE     = 1'b1,
   parameter int ALMOST      = 2
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic                  Clr,
   input  logic                  Inc,
   output logic                  Ack,
   output logic [ADDR_WIDTH-1:0] Addr,
   output logic [ADDR_WIDTH:0]   Ptr_gray,
   input  logic [ADDR_WIDTH:0]   Rmt_gray,
   output logic                  Flag,
   output logic                  Almost,
   output logic [ADDR_WIDTH:0]   Level,
   output logic                  Err
);

   localparam int         A        = ADDR_WIDTH;
   localparam int         PW       = ADDR_WIDTH + 1;
   localparam logic [A:0] DEPTH    = {1'b1, {A{1'b0}}};
   localparam logic [A:0] ALM_HI   = DEPTH - PW'(ALMOST);
   localparam logic [A:0] ALM_LO   = PW'(ALMOST);
   // Read side comes out of reset/clear empty, write side not full.
   localparam bit         FLAG_RST = ~WR_SIDE;

   logic [A:0] ptr_bin;
   logic [A:0] gray_q;
   logic [A:0] level_q;
   logic       flag_q;
   logic       almost_q;
   logic       err_q;

   logic [A:0] sync_q [SYNC_STAGES];
   logic [A:0] rsync;
   logic [A:0] rbin;

   logic       ack;
   logic [A:0] nbin;
   logic [A:0] ngray;
   logic [A:0] full_pat;
   logic [A:0] level_nxt;
   logic       flag_nxt;
   logic       almost_nxt;

   // Remote pointer synchroniser. Only reset clears it; Clr leaves it running
   // so the view of the other domain stays current across a local clear.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= Rmt_gray;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign rsync = sync_q[SYNC_STAGES-1];

   // Gray -> binary: bit i is the XOR of all Gray bits from the MSB down to i.
   always_comb begin
      rbin = '0;
      for (int i = 0; i <= A; i++) begin
         rbin[i] = ^(rsync >> i);
      end
   end

   assign ack   = Inc & ~flag_q;
   assign nbin  = ptr_bin + {{A{1'b0}}, ack};
   assign ngray = nbin ^ (nbin >> 1);

   // Full when the write pointer is exactly one lap ahead: in Gray code that
   // is the remote pointer with its top two bits inverted.
   assign full_pat = {~rsync[A:A-1], rsync[A-2:0]};

   // Flags and level are computed from the next local pointer so a local
   // advance is reflected on the same edge; the remote side is seen late,
   // which only ever makes full/empty pessimistic.
   always_comb begin
      if (WR_SIDE) begin
         level_nxt  = nbin - rbin;
         flag_nxt   = (ngray == full_pat);
         almost_nxt = (level_nxt >= ALM_HI);
      end else begin
         level_nxt  = rbin - nbin;
         flag_nxt   = (ngray == rsync);
         almost_nxt = (level_nxt <= ALM_LO);
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n || Clr) begin
         ptr_bin  <= '0;
         gray_q   <= '0;
         level_q  <= '0;
         flag_q   <= FLAG_RST;
         almost_q <= FLAG_RST;
         err_q    <= 1'b0;
      end else begin
         ptr_bin  <= nbin;
         gray_q   <= ngray;
         level_q  <= level_nxt;
         flag_q   <= flag_nxt;
         almost_q <= almost_nxt;
         if (Inc && flag_q) begin
            err_q <= 1'b1;
         end
      end
   end

   assign Ack      = ack;
   assign Addr     = ptr_bin[A-1:0];
   assign Ptr_gray = gray_q;
   assign Flag     = flag_q;
   assign Almost   = almost_q;
   assign Level    = level_q;
   assign Err      = err_q;

endmodule

// File: tb/tb_gray_ptr_ctrl.sv
// Purpose : exercises a write-side and a read-side gray_ptr_ctrl against an occupancy-arithmetic model.
// Latency : expectations are queued one cycle ahead and compared on the falling edge.
// Backpr. : none; both instances are driven every cycle.
module tb_gray_ptr_ctrl;

   localparam int SYNC = 2;

   logic       clk;
   logic       rst_n;
   logic       clr_w, inc_w, clr_r, inc_r;
   int         rb_w, rb_r;
   logic [4:0] rg_w, rg_r;

   logic       ack_w, ack_r, flag_w, flag_r, alm_w, alm_r, err_w, err_r;
   logic [3:0] addr_w, addr_r;
   logic [4:0] gray_w, gray_r, lvl_w, lvl_r;

   int checks = 0;
   int errors = 0;

   function automatic logic [4:0] g5(int b);
      logic [4:0] v;
      v = 5'(b);
      return v ^ (v >> 1);
   endfunction

   assign rg_w = g5(rb_w);
   assign rg_r = g5(rb_r);

   gray_ptr_ctrl #(.ADDR_WIDTH(4), .SYNC_STAGES(SYNC), .WR_SIDE(1'b1), .ALMOST(2)) u_wr (
      .Clk(clk), .Rst_n(rst_n), .Clr(clr_w), .Inc(inc_w), .Ack(ack_w), .Addr(addr_w),
      .Ptr_gray(gray_w), .Rmt_gray(rg_w), .Flag(flag_w), .Almost(alm_w), .Level(lvl_w), .Err(err_w)
   );

   gray_ptr_ctrl #(.ADDR_WIDTH(4), .SYNC_STAGES(SYNC), .WR_SIDE(1'b0), .ALMOST(2)) u_rd (
      .Clk(clk), .Rst_n(rst_n), .Clr(clr_r), .Inc(inc_r), .Ack(ack_r), .Addr(addr_r),
      .Ptr_gray(gray_r), .Rmt_gray(rg_r), .Flag(flag_r), .Almost(alm_r), .Level(lvl_r), .Err(err_r)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: index 1 = write side, 0 = read side.
   int lbin [2];
   int lvl  [2];
   bit flg  [2];
   bit alm  [2];
   bit er   [2];
   bit stp  [2];
   int rq   [2][SYNC];
   bit known = 1'b0;

   typedef struct {
      bit         ack_w, ack_r;
      logic [3:0] addr_w, addr_r;
      logic [4:0] g_w, g_r, l_w, l_r;
      bit         f_w, f_r, a_w, a_r, e_w, e_r;
      bit         stepw;
   } exp_t;

   exp_t sbq[$];

   task automatic model_edge(int s, bit rst, bit clr, bit inc, int rmt);
      int r, nb, occ;
      bit ack;
      r   = rq[s][0];
      ack = inc && !flg[s];
      stp[s] = 1'b0;
      if (!rst) begin
         lbin[s] = 0; lvl[s] = 0; er[s] = 1'b0;
         flg[s] = (s == 0); alm[s] = (s == 0);
         for (int k = 0; k < SYNC; k++) rq[s][k] = 0;
         return;
      end
      for (int k = 0; k < SYNC - 1; k++) rq[s][k] = rq[s][k+1];
      rq[s][SYNC-1] = rmt & 31;
      if (clr) begin
         lbin[s] = 0; lvl[s] = 0; er[s] = 1'b0;
         flg[s] = (s == 0); alm[s] = (s == 0);
      end else begin
         if (inc && flg[s]) er[s] = 1'b1;
         nb  = (lbin[s] + int'(ack)) % 32;
         occ = (s == 1) ? ((nb - r) & 31) : ((r - nb) & 31);
         flg[s] = (s == 1) ? (occ == 16) : (occ == 0);
         alm[s] = (s == 1) ? (occ >= 14) : (occ <= 2);
         lvl[s] = occ;
         stp[s] = ack;
         lbin[s] = nb;
      end
   endtask

   // Queue the expectation for the current cycle, then advance one edge.
   task automatic step();
      exp_t e;
      if (known) begin
         e.ack_w = inc_w && !flg[1];   e.ack_r = inc_r && !flg[0];
         e.addr_w = 4'(lbin[1]);       e.addr_r = 4'(lbin[0]);
         e.g_w = g5(lbin[1]);          e.g_r = g5(lbin[0]);
         e.l_w = 5'(lvl[1]);           e.l_r = 5'(lvl[0]);
         e.f_w = flg[1]; e.f_r = flg[0];
         e.a_w = alm[1]; e.a_r = alm[0];
         e.e_w = er[1];  e.e_r = er[0];
         e.stepw = stp[1];
         sbq.push_back(e);
      end
      @(posedge clk);
      model_edge(1, rst_n, clr_w, inc_w, rb_w);
      model_edge(0, rst_n, clr_r, inc_r, rb_r);
      if (!rst_n) known = 1'b1;
      #2;
   endtask

   task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one expectation per cycle and compares the live outputs.
   logic [4:0] prev_gw = '0;
   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("ack_w",  8'(ack_w),  8'(e.ack_w));
         chk("ack_r",  8'(ack_r),  8'(e.ack_r));
         chk("addr_w", 8'(addr_w), 8'(e.addr_w));
         chk("addr_r", 8'(addr_r), 8'(e.addr_r));
         chk("gray_w", 8'(gray_w), 8'(e.g_w));
         chk("gray_r", 8'(gray_r), 8'(e.g_r));
         chk("flag_w", 8'(flag_w), 8'(e.f_w));
         chk("flag_r", 8'(flag_r), 8'(e.f_r));
         chk("alm_w",  8'(alm_w),  8'(e.a_w));
         chk("alm_r",  8'(alm_r),  8'(e.a_r));
         chk("lvl_w",  8'(lvl_w),  8'(e.l_w));
         chk("lvl_r",  8'(lvl_r),  8'(e.l_r));
         chk("err_w",  8'(err_w),  8'(e.e_w));
         chk("err_r",  8'(err_r),  8'(e.e_r));
         if (e.stepw) chk("gray_w_onebit", 8'($countones(gray_w ^ prev_gw)), 8'd1);
      end
      prev_gw = gray_w;
   end

   initial begin
      rst_n = 1'b0; clr_w = 1'b0; inc_w = 1'b0; clr_r = 1'b0; inc_r = 1'b0;
      rb_w = 0; rb_r = 0;

      // Reset for two edges.
      repeat (2) step();
      rst_n = 1'b1;
      step();

      // Write fill from empty: 16 accepted, 17th rejected and flags Err.
      inc_w = 1'b1;
      repeat (17) step();
      inc_w = 1'b0;
      step();

      // Read side: remote write pointer jumps to 3, then drain it.
      rb_r = 3;
      repeat (4) step();
      inc_r = 1'b1;
      repeat (3) step();
      inc_r = 1'b0;
      step();

      // Write full, remote reader advances by one; Inc once Flag drops.
      rb_w = 1;
      repeat (3) step();
      inc_w = 1'b1;
      step();
      inc_w = 1'b0;
      step();

      // Clear, count to 9, then Clr together with Inc.
      clr_w = 1'b1; rb_w = 0;
      step();
      clr_w = 1'b0;
      repeat (3) step();
      inc_w = 1'b1;
      repeat (9) step();
      clr_w = 1'b1;
      step();
      clr_w = 1'b0; inc_w = 1'b0;
      step();

      // Full Gray lap with the remote reader tracking closely behind.
      inc_w = 1'b1;
      for (int i = 0; i < 32; i++) begin
         rb_w = lbin[1];
         step();
      end
      inc_w = 1'b0;
      repeat (3) step();

      // Random traffic on both sides with legal remote pointer motion.
      for (int i = 0; i < 2000; i++) begin
         inc_w = 1'($urandom_range(0, 1));
         inc_r = 1'($urandom_range(0, 1));
         clr_w = ($urandom_range(0, 63) == 0);
         clr_r = ($urandom_range(0, 63) == 0);
         if (clr_w) rb_w = 0;
         else if (rb_w != lbin[1] && $urandom_range(0, 1) == 1) rb_w = (rb_w + 1) % 32;
         if (clr_r) rb_r = 0;
         else if (((rb_r - lbin[0]) & 31) < 16 && $urandom_range(0, 1) == 1) rb_r = (rb_r + 1) % 32;
         step();
      end
      inc_w = 1'b0; inc_r = 1'b0; clr_w = 1'b0; clr_r = 1'b0;
      repeat (4) step();

      // Let the monitor drain, bounded.
      for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
      #1;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
